// File: rtl/trace_emitter.sv
// rtl/trace_emitter.sv - CPU trace snapshot capture and 12-byte checksummed frame serialiser
module trace_emitter #(
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cap,
  input  logic [7:0]  pc,
  input  logic [7:0]  ir,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  x,
  input  logic [7:0]  q,
  input  logic [13:0] ctrl,      // ctrl[13] is control bit 1 (most significant)
  input  logic [7:0]  dbus,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [7:0]  overrun
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [79:0] r_cur;            // frame bytes 1..10, byte 1 in the top octet
  logic [79:0] r_pend;
  logic        r_cur_full;
  logic        r_pend_full;
  logic [3:0]  r_idx;
  logic [7:0]  r_seq;
  logic [7:0]  r_overrun;

  logic [79:0] w_snap;
  logic [7:0]  w_cur_b [1:10];
  logic [7:0]  w_sum;
  logic [7:0]  w_chk;
  logic [7:0]  w_byte;
  logic        w_accept;
  logic        w_last;

  // The snapshot is stored already packed in frame order so the send path is a plain byte mux.
  assign w_snap   = {r_seq, pc, ir, a, b, x, q, 2'b00, ctrl[13:8], ctrl[7:0], dbus};
  assign w_accept = out_valid && out_ready;
  assign w_last   = w_accept && (r_idx == 4'd11);
  assign busy     = r_cur_full || r_pend_full;
  assign overrun  = r_overrun;

  // Split the in-flight snapshot into bytes and form the checksum over bytes 1..10.
  always_comb begin
    w_sum = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      w_cur_b[i] = r_cur[(10 - i) * 8 +: 8];
      w_sum      = w_sum + w_cur_b[i];
    end
    w_chk = 8'h00 - w_sum;
  end

  // Select the frame byte addressed by the send index.
  always_comb begin
    w_byte = SYNC;
    if (r_idx == 4'd11) begin
      w_byte = w_chk;
    end else if (r_idx != 4'd0) begin
      w_byte = w_cur_b[r_idx];
    end
  end

  // Slot management, sequence numbering, overrun counting and byte index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cur       <= '0;
      r_pend      <= '0;
      r_cur_full  <= 1'b0;
      r_pend_full <= 1'b0;
      r_idx       <= 4'd0;
      r_seq       <= 8'h00;
      r_overrun   <= 8'h00;
    end else begin
      if (w_accept) begin
        r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
      end
      if (w_last) begin
        // cur is freed this edge, so a capture is never dropped here.
        if (r_pend_full) begin
          r_cur <= r_pend;
          if (cap) begin
            r_pend <= w_snap;
          end else begin
            r_pend_full <= 1'b0;
          end
        end else if (cap) begin
          r_cur <= w_snap;
        end else begin
          r_cur_full <= 1'b0;
        end
        if (cap) begin
          r_seq <= r_seq + 8'd1;
        end
      end else if (!r_cur_full) begin
        if (cap) begin
          r_cur      <= w_snap;
          r_cur_full <= 1'b1;
          r_seq      <= r_seq + 8'd1;
        end
      end else if (cap) begin
        if (!r_pend_full) begin
          r_pend      <= w_snap;
          r_pend_full <= 1'b1;
          r_seq       <= r_seq + 8'd1;
        end else if (r_overrun != 8'hFF) begin
          r_overrun <= r_overrun + 8'd1;
        end
      end
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and stream outputs; IDLE leaves on the edge that loads cur so SYNC appears right after capture.
  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (cap) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = w_byte;
        if (w_last && !r_pend_full && !cap) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trace_emitter.sv
// tb/tb_trace_emitter.sv - directed self-checking bench for trace_emitter
module tb_trace_emitter;

  logic        clk;
  logic        reset;
  logic        cap;
  logic [7:0]  pc, ir, a, b, x, q, dbus;
  logic [13:0] ctrl;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [7:0]  overrun;

  int          n_vec;
  int          n_err;
  logic [7:0]  seq_m;
  logic [7:0]  got [12];

  trace_emitter #(.SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset), .cap(cap),
    .pc(pc), .ir(ir), .a(a), .b(b), .x(x), .q(q),
    .ctrl(ctrl), .dbus(dbus),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] mk_frame(input logic [7:0] s, input logic [7:0] p,
                                           input logic [7:0] i_r, input logic [7:0] ra,
                                           input logic [7:0] rb, input logic [7:0] rx,
                                           input logic [7:0] rq, input logic [13:0] c,
                                           input logic [7:0] d);
    logic [7:0] sum;
    sum = s + p + i_r + ra + rb + rx + rq + {2'b00, c[13:8]} + c[7:0] + d;
    return {8'hA5, s, p, i_r, ra, rb, rx, rq, 2'b00, c[13:8], c[7:0], d, 8'h00 - sum};
  endfunction

  task automatic set_snap(input logic [7:0] p, input logic [13:0] c);
    pc = p; ir = 8'h21; a = 8'h01; b = 8'h02; x = 8'h03; q = 8'h04; ctrl = c; dbus = 8'h21;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", out_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (overrun !== 8'h00) begin n_err++; $display("FAIL reset_overrun got %h want 00", overrun); end
  endtask

  task automatic test_single();
    logic [95:0] exp;
    exp = 96'hA5_00_10_21_01_02_03_04_00_00_21_A4;
    set_snap(8'h10, 14'd0);
    out_ready = 1'b1; cap = 1'b1;
    step(); cap = 1'b0; seq_m++;
    for (int c = 0; c < 12; c++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp[95-8*c -: 8]) begin
        n_err++; $display("FAIL single_byte%0d got %b/%h want 1/%h", c, out_valid, out_data, exp[95-8*c -: 8]);
      end
      step();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_end_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_end_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [95:0] exp;
    int n, cyc;
    logic prev_stall;
    logic [7:0] prev_data;
    exp = mk_frame(seq_m, 8'h10, 8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 14'd0, 8'h21);
    set_snap(8'h10, 14'd0);
    out_ready = 1'b0; cap = 1'b1;
    step(); cap = 1'b0; seq_m++;
    n = 0; cyc = 0; prev_stall = 1'b0; prev_data = 8'h00;
    while (n < 12 && cyc < 100) begin
      out_ready = ((cyc % 2) == 1);
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_err++; $display("FAIL bp_stall_hold got %b/%h want 1/%h", out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin got[n] = out_data; n++; end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      step(); cyc++;
    end
    out_ready = 1'b1;
    n_vec++; if (n != 12) begin n_err++; $display("FAIL bp_byte_count got %0d want 12", n); end
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      if (got[i] !== exp[95-8*i -: 8]) begin n_err++; $display("FAIL bp_byte%0d got %h want %h", i, got[i], exp[95-8*i -: 8]); end
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_end_valid got %b want 0", out_valid); end
  endtask

  task automatic test_ctrl_packing();
    set_snap(8'h10, 14'b10000000000001);
    out_ready = 1'b1; cap = 1'b1;
    step(); cap = 1'b0; seq_m++;
    for (int c = 0; c < 12; c++) begin got[c] = out_valid ? out_data : 8'hXX; step(); end
    n_vec++; if (got[1] !== 8'h02) begin n_err++; $display("FAIL ctrl_seq got %h want 02", got[1]); end
    n_vec++; if (got[8] !== 8'h20) begin n_err++; $display("FAIL ctrl_byte8 got %h want 20", got[8]); end
    n_vec++; if (got[9] !== 8'h01) begin n_err++; $display("FAIL ctrl_byte9 got %h want 01", got[9]); end
    n_vec++; if (got[11] !== 8'h81) begin n_err++; $display("FAIL ctrl_chk got %h want 81", got[11]); end
  endtask

  task automatic test_overrun();
    logic [95:0] ef [2];
    logic [7:0] bt;
    int w;
    ef[0] = mk_frame(seq_m, 8'h30, 8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 14'd0, 8'h21);
    ef[1] = mk_frame(seq_m + 8'd1, 8'h31, 8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 14'd0, 8'h21);
    set_snap(8'h30, 14'd0);
    out_ready = 1'b1; cap = 1'b1;
    step();
    for (int c = 0; c < 24; c++) begin
      cap = (c < 2);
      pc  = (c == 0) ? 8'h31 : 8'h32;
      bt  = ef[c/12][95-8*(c%12) -: 8];
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== bt) begin
        n_err++; $display("FAIL ovr_byte%0d got %b/%h want 1/%h", c, out_valid, out_data, bt);
      end
      step();
    end
    seq_m = seq_m + 8'd2;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_end_valid got %b want 0", out_valid); end
    n_vec++; if (overrun !== 8'h01) begin n_err++; $display("FAIL ovr_count got %h want 01", overrun); end
    for (int t = 2; t <= 300; t++) begin
      cap = 1'b1;
      repeat (3) step();
      cap = 1'b0;
      seq_m = seq_m + 8'd2;
      w = 0;
      while (busy && w < 60) begin step(); w++; end
      if (w >= 60) begin n_vec++; n_err++; $display("FAIL ovr_drain_timeout got busy=1 want 0"); end
      if (t == 254) begin
        n_vec++; if (overrun !== 8'hFE) begin n_err++; $display("FAIL ovr_254 got %h want FE", overrun); end
      end
      if (t == 255) begin
        n_vec++; if (overrun !== 8'hFF) begin n_err++; $display("FAIL ovr_255 got %h want FF", overrun); end
      end
    end
    n_vec++; if (overrun !== 8'hFF) begin n_err++; $display("FAIL ovr_300 got %h want FF", overrun); end
  endtask

  task automatic test_simul_pend_empty();
    logic [95:0] ef [2];
    logic [7:0] bt;
    ef[0] = mk_frame(seq_m, 8'h40, 8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 14'd0, 8'h21);
    ef[1] = mk_frame(seq_m + 8'd1, 8'h41, 8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 14'd0, 8'h21);
    set_snap(8'h40, 14'd0);
    out_ready = 1'b1; cap = 1'b1;
    step();
    for (int c = 0; c < 24; c++) begin
      cap = (c == 11);
      if (c == 11) pc = 8'h41;
      bt = ef[c/12][95-8*(c%12) -: 8];
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== bt) begin
        n_err++; $display("FAIL simul_empty_byte%0d got %b/%h want 1/%h", c, out_valid, out_data, bt);
      end
      step();
    end
    seq_m = seq_m + 8'd2;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty_end got %b want 0", out_valid); end
  endtask

  task automatic test_simul_pend_full();
    logic [95:0] ef [3];
    logic [7:0] bt;
    ef[0] = mk_frame(seq_m, 8'h50, 8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 14'd0, 8'h21);
    ef[1] = mk_frame(seq_m + 8'd1, 8'h51, 8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 14'd0, 8'h21);
    ef[2] = mk_frame(seq_m + 8'd2, 8'h52, 8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 14'd0, 8'h21);
    set_snap(8'h50, 14'd0);
    out_ready = 1'b1; cap = 1'b1;
    step();
    for (int c = 0; c < 36; c++) begin
      cap = (c == 0) || (c == 11);
      if (c == 0) pc = 8'h51;
      if (c == 11) pc = 8'h52;
      bt = ef[c/12][95-8*(c%12) -: 8];
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== bt) begin
        n_err++; $display("FAIL simul_full_byte%0d got %b/%h want 1/%h", c, out_valid, out_data, bt);
      end
      step();
    end
    seq_m = seq_m + 8'd3;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL simul_full_end got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [95:0] exp;
    set_snap(8'h60, 14'd0);
    out_ready = 1'b1; cap = 1'b1;
    step(); cap = 1'b0;
    for (int c = 0; c < 5; c++) step();
    reset = 1'b0; cap = 1'b1;
    step();
    reset = 1'b1; cap = 1'b0; seq_m = 8'h00;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    n_vec++; if (overrun !== 8'h00) begin n_err++; $display("FAIL rstmid_overrun got %h want 00", overrun); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_capignored got %b want 0", out_valid); end
    exp = mk_frame(8'h00, 8'h61, 8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 14'd0, 8'h21);
    pc = 8'h61; cap = 1'b1;
    step(); cap = 1'b0;
    for (int c = 0; c < 12; c++) begin got[c] = out_valid ? out_data : 8'hXX; step(); end
    n_vec++; if (got[0] !== 8'hA5) begin n_err++; $display("FAIL rstmid_sync got %h want A5", got[0]); end
    n_vec++; if (got[1] !== 8'h00) begin n_err++; $display("FAIL rstmid_seq got %h want 00", got[1]); end
    n_vec++; if (got[11] !== exp[7:0]) begin n_err++; $display("FAIL rstmid_chk got %h want %h", got[11], exp[7:0]); end
  endtask

  initial begin
    n_vec = 0; n_err = 0; seq_m = 8'h00;
    reset = 1'b0; cap = 1'b0; out_ready = 1'b1;
    set_snap(8'h00, 14'd0);
    step(); step();
    test_reset();
    reset = 1'b1;
    step();
    test_single();
    test_backpressure();
    test_ctrl_packing();
    test_overrun();
    test_simul_pend_empty();
    test_simul_pend_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trace_emitter.md
# trace_emitter

Hardware-side source of the per-cycle CPU trace. It captures a snapshot of CPU state on a strobe: pc, ir, A/B/X/Q register contents, the 14 control bits and dbus. It serialises each snapshot as a checksummed 12-byte frame over a valid/ready byte stream. The frame is what the trace monitor consumes; the emitter sits beside `whole_cpu` and drives a byte sink such as a UART transmitter or a test port.

## Interface
- `SYNC`, default 8'hA5: frame start byte.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; 0 at a rising edge resets the block.
- `cap` in 1: capture strobe; snapshot taken at a rising edge where `cap`=1.
- `pc`, `ir`, `a`, `b`, `x`, `q`, `dbus` in 8 each: CPU state to capture.
- `ctrl` in [1:14]: control bits; `ctrl[1]` is most significant.
- `out_data` out 8: current frame byte.
- `out_valid` out 1: `out_data` holds a valid byte.
- `out_ready` in 1: sink accepts the byte.
- `busy` out 1: a frame is in flight or a snapshot is pending.
- `overrun` out 8: saturating count of dropped snapshots.

## Operation
- Two snapshot slots:
  - `cur` is the frame being sent.
  - `pend` holds one waiting snapshot.
- Capture at an edge where `cap`=1:
  - `cur` empty, or being freed this edge: load into `cur`.
  - Otherwise `pend` empty: load into `pend`.
  - Otherwise: drop the snapshot and increment `overrun`, saturating at 8'hFF.
- `seq` is an 8-bit counter latched with each accepted snapshot. It increments per accepted snapshot, wraps 8'hFF→8'h00, and is not incremented for dropped snapshots.
- Frame byte order (index 0..11):
  - 0 `SYNC`, 1 `seq`, 2 `pc`, 3 `ir`, 4 `a`, 5 `b`, 6 `x`, 7 `q`
  - 8 {2'b00, `ctrl[1:6]`}, 9 `ctrl[7:14]`, 10 `dbus`, 11 `chk`
- `chk` = two's complement of the mod-256 sum of bytes 1..10, so the sum of bytes 1..11 ≡ 0 mod 256. `SYNC` is excluded.
- FSM states:
  - IDLE: `out_valid`=0. Go to SEND (index 0) when `cur` is full.
  - SEND: `out_valid`=1, `out_data`=byte[index]. On accept, index+1.
  - On accept of byte 11: `cur` becomes `pend` (if full) and the block stays in SEND with index 0. Else `cur` empties and the block goes to IDLE.
- `busy` = `cur` full or `pend` full.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=8'h00, `busy`=0, `overrun`=0.
  - `seq` resets to 0; both slots empty; FSM in IDLE.
- Latency: capture at edge N into an idle block gives `out_valid`=1 with `SYNC` after edge N. Byte 0 is accepted no earlier than edge N+1.
- A byte transfers at an edge where `out_valid`=1 and `out_ready`=1.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold unchanged. Captured fields never alter an in-flight frame.
- Full throughput: with `out_ready` held high, one byte per cycle. A frame takes 12 cycles.
  - Back-to-back frames from `pend` have no IDLE gap: byte 11 of frame k is followed next cycle by `SYNC` of frame k+1.
- Simultaneous capture and final-byte accept, `pend` empty: the new snapshot goes straight to `cur` and is sent next without a gap.
- Simultaneous capture and final-byte accept, `pend` full: `pend` moves to `cur` and the new snapshot moves into `pend`; nothing is dropped.
- `out_ready` is ignored when `out_valid`=0.
- Reset asserted mid-frame:
  - The frame is abandoned; `out_valid`=0 after that edge.
  - Both slots are cleared; `seq` and `overrun` are cleared.
  - A `cap` in the same cycle is ignored.

## Test plan
- Single capture, sink always ready:
  - Stimulus: `pc`=10, `ir`=21, `a`=01, `b`=02, `x`=03, `q`=04, `ctrl`=0, `dbus`=21 (all hex).
  - Expect 12 consecutive bytes A5,00,10,21,01,02,03,04,00,00,21,A4, then `out_valid`=0 and `busy`=0.
- Backpressure: same snapshot, `out_ready` toggled 0/1 every cycle.
  - Expect the identical byte sequence, with `out_data` stable across every stalled cycle.
- Control packing: `ctrl`=14'b10000000000001.
  - Expect byte 8 = 20 and byte 9 = 01 (hex); checksum adjusts accordingly.
- Overrun: three `cap` pulses on consecutive cycles, sink ready.
  - Expect frames with `seq` 00 and 01 sent back-to-back (24 cycles, no gap).
  - Third snapshot dropped; `overrun`=1.
  - 300 such triples total → `overrun` saturates at FF.
- Simultaneous capture and final accept (both slot cases):
  - Expect no dropped frame, `seq` contiguous, no IDLE cycle between frames.
- Reset mid-frame: `reset`=0 for one edge during byte 5.
  - Expect `out_valid`=0 and `overrun`=0 after that edge.
  - Next capture yields a frame starting A5,00.
